// File: rtl/branch_predictor_2bc.sv
// Direct-mapped table of saturating counters with saturating branch/mispredict statistics.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module branch_predictor_2bc #(
  parameter int unsigned INDEX_BITS   = 6,
  parameter int unsigned COUNTER_BITS = 2,
  parameter int unsigned HIST_BITS    = 6,
  parameter int unsigned STAT_BITS    = 32
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic [31:0]           PCF,
  output logic                  PrPCSrcF,
  output logic [INDEX_BITS-1:0] PredIdxF,
  input  logic                  BranchM,
  input  logic [INDEX_BITS-1:0] PredIdxM,
  input  logic                  TakenM,
  input  logic                  MispredM,
  output logic [STAT_BITS-1:0]  BranchCount,
  output logic [STAT_BITS-1:0]  MispredCount
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;
  localparam logic [COUNTER_BITS-1:0] CtrInit = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);
  localparam logic [COUNTER_BITS-1:0] CtrMax  = {COUNTER_BITS{1'b1}};

  logic [COUNTER_BITS-1:0] r_ctr [Entries];
  logic [STAT_BITS-1:0]    r_branch_cnt;
  logic [STAT_BITS-1:0]    r_mispred_cnt;

  logic [INDEX_BITS-1:0]   w_base_idx;
  logic [COUNTER_BITS-1:0] w_ctr_rd;
  logic [COUNTER_BITS-1:0] w_ctr_old;
  logic [COUNTER_BITS-1:0] w_ctr_new;
  logic                    w_unused_pcf;

  assign w_base_idx   = PCF[INDEX_BITS+1:2];
  assign w_unused_pcf = ^{PCF[31:INDEX_BITS+2], PCF[1:0]};

`ifdef BHT_GSHARE_EN
  logic [HIST_BITS-1:0] r_ghr;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_ghr <= '0;
    end else if (BranchM) begin
      // Truncating the concatenation drops the oldest bit; also covers HIST_BITS == 1.
      r_ghr <= HIST_BITS'({r_ghr, TakenM});
    end
  end

  assign PredIdxF = w_base_idx ^ INDEX_BITS'(r_ghr);
`else
  assign PredIdxF = w_base_idx;
`endif

  // Lookup reads the registered table only, so a same-cycle training write is not bypassed.
  assign w_ctr_rd = r_ctr[PredIdxF];
  assign PrPCSrcF = w_ctr_rd[COUNTER_BITS-1];

  always_comb begin
    w_ctr_old = r_ctr[PredIdxM];
    w_ctr_new = w_ctr_old;
    if (TakenM) begin
      if (w_ctr_old != CtrMax) w_ctr_new = w_ctr_old + COUNTER_BITS'(1);
    end else begin
      if (w_ctr_old != '0) w_ctr_new = w_ctr_old - COUNTER_BITS'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < Entries; i++) begin
        r_ctr[i] <= CtrInit;
      end
    end else if (BranchM) begin
      r_ctr[PredIdxM] <= w_ctr_new;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (BranchM) begin
      if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + STAT_BITS'(1);
      if (MispredM && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + STAT_BITS'(1);
    end
  end

  assign BranchCount  = r_branch_cnt;
  assign MispredCount = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor_2bc.sv
// Scoreboard bench: driver pushes model expectations, a negedge monitor pops and compares.
// A second instance with 4-bit statistics exercises counter saturation.
module tb_branch_predictor_2bc;

  localparam int unsigned IB      = 6;
  localparam int unsigned CB      = 2;
  localparam int unsigned HB      = 6;
  localparam int unsigned ENTRIES = 1 << IB;
  localparam int          HALF    = 1 << (CB - 1);
  localparam int          CMAX    = (1 << CB) - 1;
  localparam longint      SMAX32  = 64'hFFFF_FFFF;
  localparam longint      SMAX4   = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pcf = '0;
  logic          br = 1'b0;
  logic [IB-1:0] idx_m = '0;
  logic          taken = 1'b0;
  logic          mispred = 1'b0;

  logic          pred, pred4;
  logic [IB-1:0] idx_f, idx_f4;
  logic [31:0]   bcnt, mcnt;
  logic [3:0]    bcnt4, mcnt4;

  branch_predictor_2bc #(
    .INDEX_BITS(IB), .COUNTER_BITS(CB), .HIST_BITS(HB), .STAT_BITS(32)
  ) u_dut (
    .CLK(clk), .RESETn(rst_n), .PCF(pcf), .PrPCSrcF(pred), .PredIdxF(idx_f),
    .BranchM(br), .PredIdxM(idx_m), .TakenM(taken), .MispredM(mispred),
    .BranchCount(bcnt), .MispredCount(mcnt)
  );

  branch_predictor_2bc #(
    .INDEX_BITS(IB), .COUNTER_BITS(CB), .HIST_BITS(HB), .STAT_BITS(4)
  ) u_dut4 (
    .CLK(clk), .RESETn(rst_n), .PCF(pcf), .PrPCSrcF(pred4), .PredIdxF(idx_f4),
    .BranchM(br), .PredIdxM(idx_m), .TakenM(taken), .MispredM(mispred),
    .BranchCount(bcnt4), .MispredCount(mcnt4)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, saturation by min/max, history as a shifted number.
  int     m_ctr [ENTRIES];
  int     m_ghr;
  longint m_bc, m_mc;

  typedef struct {
    string  tag;
    bit     pred;
    int     idx;
    longint bc, mc, bc4, mc4;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   failures = 0;

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int model_idx(input logic [31:0] pc);
    int base;
    base = int'((pc >> 2) % ENTRIES);
`ifdef BHT_GSHARE_EN
    return base ^ m_ghr;
`else
    return base;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_ctr[i] = HALF - 1;
    m_ghr = 0;
    m_bc  = 0;
    m_mc  = 0;
  endtask

  task automatic model_train(input int i, input bit tk, input bit mp);
    if (tk) m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
    else    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    m_ghr = ((m_ghr * 2) + (tk ? 1 : 0)) % (1 << HB);
    m_bc  = m_bc + 1;
    if (mp) m_mc = m_mc + 1;
  endtask

  task automatic push_expect(input string tag);
    exp_t e;
    e.tag  = tag;
    e.idx  = model_idx(pcf);
    e.pred = (m_ctr[e.idx] >= HALF);
    e.bc   = sat(m_bc, SMAX32);
    e.mc   = sat(m_mc, SMAX32);
    e.bc4  = sat(m_bc, SMAX4);
    e.mc4  = sat(m_mc, SMAX4);
    exp_q.push_back(e);
  endtask

  task automatic step(input string tag, input logic [31:0] pc, input bit b, input int i,
                      input bit tk, input bit mp);
    @(posedge clk);
    #1;
    pcf     = pc;
    br      = b;
    idx_m   = i[IB-1:0];
    taken   = tk;
    mispred = mp;
    push_expect(tag);
    if (b) model_train(i, tk, mp);
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".pred"},  longint'(pred),  longint'(e.pred));
      chk({e.tag, ".idx"},   longint'(idx_f), longint'(e.idx));
      chk({e.tag, ".bcnt"},  longint'(bcnt),  e.bc);
      chk({e.tag, ".mcnt"},  longint'(mcnt),  e.mc);
      chk({e.tag, ".bcnt4"}, longint'(bcnt4), e.bc4);
      chk({e.tag, ".mcnt4"}, longint'(mcnt4), e.mc4);
      chk({e.tag, ".pred4"}, longint'(pred4), longint'(e.pred));
    end
  end

  task automatic async_reset();
    @(posedge clk);
    #1;
    br = 1'b0;
    pcf = 32'h40;
    #2;
    rst_n = 1'b0;
    model_reset();
    push_expect("areset_mid");
    // Held in reset across an edge with a training request present: nothing may change.
    @(posedge clk);
    #1;
    br = 1'b1; idx_m = 6'd16; taken = 1'b1; mispred = 1'b1;
    push_expect("areset_hold");
    @(posedge clk);
    #1;
    br = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #22;
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) step("reset_sweep", 32'(i * 4), 1'b0, 0, 1'b0, 1'b0);

    // Hysteresis and saturation on entry 16, looked up from PC 0x40.
    step("hys_t1", 32'h40, 1'b1, 16, 1'b1, 1'b0);
    step("hys_t2", 32'h40, 1'b1, 16, 1'b1, 1'b0);
    step("hys_t3", 32'h40, 1'b1, 16, 1'b1, 1'b0);
    step("hys_n1", 32'h40, 1'b1, 16, 1'b0, 1'b0);
    step("hys_n2", 32'h40, 1'b1, 16, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("hys_sat0", 32'h40, 1'b1, 16, 1'b0, 1'b0);
    step("hys_look", 32'h40, 1'b0, 0, 1'b0, 1'b0);

    async_reset();

    // Same-cycle read and write, then statistics with idle mispredict noise.
    step("same_cyc", 32'h40, 1'b1, 16, 1'b1, 1'b0);
    step("same_nxt", 32'h40, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      step("stats", 32'h80, 1'b1, i + 1, i[0], (i % 4) == 1);
    for (int i = 0; i < 4; i++) step("stats_idle", 32'h80, 1'b0, 16, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step("stats_sat", 32'h100, 1'b1, 40, 1'b1, 1'b1);
    step("stats_look", 32'h100, 1'b0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      bit b;
      pc = $urandom();
      b  = ($urandom_range(0, 3) != 0);
      step("rand", pc, b, int'($urandom_range(0, ENTRIES - 1)), 1'($urandom()), 1'($urandom()));
    end

    async_reset();
    for (int n = 0; n < 200; n++)
      step("rand2", $urandom(), 1'($urandom()), int'($urandom_range(0, ENTRIES - 1)),
           1'($urandom()), 1'($urandom()));

    @(posedge clk);
    #1;
    br = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor_2bc.md
# branch_predictor_2bc

Parametrised successor to the 1-bit branch history table: a direct-mapped table of N-bit saturating counters looked up in Fetch and trained in Memory on every resolved conditional branch, not just on a mispredict. Fetch gets a combinational taken/not-taken prediction plus the table index it used. That index travels down the pipeline so training hits the same entry. An optional gshare mode XORs a global history register into the index. Built-in saturating counters report total resolved branches and mispredicts for performance analysis.

## Interface
- INDEX_BITS, 6, log2 of table entries; ENTRIES = 2**INDEX_BITS
- COUNTER_BITS, 2, width of each saturating counter (legal 1..4)
- HIST_BITS, 6, global history length, gshare only (legal 1..INDEX_BITS)
- STAT_BITS, 32, width of each statistics counter

- CLK  in  1  clock, all state updates on rising edge
- RESETn  in  1  asynchronous, active-low reset
- PCF  in  32  Fetch-stage PC
- PrPCSrcF  out  1  prediction: 1 = taken, 0 = not taken
- PredIdxF  out  INDEX_BITS  table index used for PrPCSrcF; pipelined to Memory by the core
- BranchM  in  1  a conditional branch is resolved in Memory this cycle
- PredIdxM  in  INDEX_BITS  PredIdxF value carried with that branch
- TakenM  in  1  actual outcome of the resolved branch
- MispredM  in  1  the branch was mispredicted (direction or target)
- BranchCount  out  STAT_BITS  resolved branches since reset
- MispredCount  out  STAT_BITS  mispredicts since reset

## Operation
- Storage: ENTRIES counters, each COUNTER_BITS wide, held in flip-flops.
- Reset value of every counter: weakly not-taken, 2**(COUNTER_BITS-1)-1. For COUNTER_BITS=1 this is 0.
- Base index: PCF[INDEX_BITS+1:2].
- PredIdxF = base index, or the gshare index (see Configuration).
- Prediction: PrPCSrcF = MSB of counter[PredIdxF].
- Training: when BranchM=1, counter[PredIdxM] is updated.
  - TakenM=1: increment, saturating at 2**COUNTER_BITS-1.
  - TakenM=0: decrement, saturating at 0.
- Training never uses PCM; it always uses PredIdxM.
- BranchM=0: no counter, history or statistic changes, whatever MispredM, TakenM or PredIdxM hold.
- Statistics:
  - BranchCount increments when BranchM=1.
  - MispredCount increments when BranchM=1 and MispredM=1.
  - Both saturate at all-ones; they never wrap.
- Reset values: all counters weakly not-taken; GHR 0; BranchCount 0; MispredCount 0.
- After reset, PrPCSrcF=0 for any PCF when COUNTER_BITS ≤ 2.

## Timing
- PrPCSrcF and PredIdxF are combinational from PCF and registered state; zero-cycle lookup.
- A training write on edge k is visible to lookups from edge k onward, i.e. the next cycle.
- Same-cycle read and write of the same index: Fetch sees the pre-update value. There is no bypass.
- GHR (gshare only) shifts on the same edge as the counter write. The new history affects PredIdxF from the next cycle.
- Stat counters update on the same edge as training.
- RESETn low asserts asynchronously, mid-operation included: all state clears immediately. Outputs reflect reset values while RESETn is low.
- Deassertion is synchronised externally by the core.

## Configuration
- BHT_GSHARE_EN defined:
  - A HIST_BITS global history register is instantiated.
  - PredIdxF = base index XOR {zero-extended GHR}.
  - On BranchM=1: GHR <= {GHR[HIST_BITS-2:0], TakenM}. For HIST_BITS=1, GHR <= TakenM.
  - The history is non-speculative: it is updated only on resolution.
- BHT_GSHARE_EN undefined:
  - No GHR flip-flops exist.
  - PredIdxF = base index.
  - HIST_BITS is ignored.

## Test plan
- **Reset values:** reset, then sweep PCF 0x0..0xFC in steps of 4 -> PrPCSrcF=0 and PredIdxF=PCF[7:2] (plain mode); BranchCount=0, MispredCount=0.
- **Hysteresis and saturation** (plain, COUNTER_BITS=2, PCF=0x40, idx 16):
  - Drive BranchM=1, TakenM=1, PredIdxM=16 for one cycle -> PrPCSrcF=1 next cycle.
  - Drive two more taken updates, then one not-taken -> PrPCSrcF still 1.
  - Drive a second not-taken -> PrPCSrcF=0.
  - Drive 5 further not-taken -> counter stays 0.
- **Same-cycle read/write:** PCF=0x40 with taken training of idx 16 on the same edge -> PrPCSrcF=0 during that cycle, 1 the following cycle.
- **Statistics:**
  - 10 resolutions with MispredM=1 on 3 of them, plus 4 cycles with MispredM=1 and BranchM=0 -> BranchCount=10, MispredCount=3.
  - With STAT_BITS=4 and 20 resolutions -> BranchCount holds at 15.
- **gshare** (BHT_GSHARE_EN, INDEX_BITS=HIST_BITS=6):
  - Train taken, taken, not-taken -> GHR=0b000110; PCF=0x40 gives PredIdxF=16^6=22.
  - A taken update at PredIdxM=22 changes only entry 22.
- **Async reset:** assert RESETn=0 mid-cycle between edges after training -> PrPCSrcF, BranchCount, MispredCount and GHR return to reset values before the next CLK edge.
